// File: rtl/layer_result_packer_if.sv
// Handshake and packed-result bus between the result sequencer, layer_result_packer and output_layer.
interface layer_result_packer_if #(
    parameter int weightNo  = 10,
    parameter int dataWidth = 16
);
    logic                              start;
    logic                              in_valid;
    logic [2*dataWidth-1:0]            in_data;
    logic                              in_ready;
    logic [weightNo*2*dataWidth-1:0]   out;
    logic                              done_out;
    logic [3:0]                        count;
    logic                              overrun;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, out, done_out, count, overrun
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, out, done_out, count, overrun
    );
endinterface

// File: rtl/layer_result_packer.sv
// Collects weightNo signed neuron results, one per handshake, into a packed score bus
// and holds it with a level done flag until the next frame begins.
module layer_result_packer #(
    parameter int weightNo  = 10,
    parameter int dataWidth = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    layer_result_packer_if.slave  bus
);
    localparam int SW = 2 * dataWidth;
    localparam int OW = weightNo * SW;
    localparam logic [3:0] LAST_SLOT = 4'(weightNo - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t         state_q, state_d;
    logic [OW-1:0]  out_q, out_d;
    logic [3:0]     count_q, count_d;
    logic           done_q, done_d;
    logic           overrun_q, overrun_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            out_q     <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            count_q   <= count_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // start has priority in every state and discards any result offered alongside it
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        count_d   = count_q;
        done_d    = done_q;
        overrun_d = overrun_q;
        if (bus.start) begin
            state_d   = COLLECT;
            out_d     = '0;
            count_d   = '0;
            done_d    = 1'b0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (bus.in_valid) begin
                        for (int k = 0; k < weightNo; k++) begin
                            if (count_q == 4'(k)) begin
                                out_d[k*SW +: SW] = bus.in_data;
                            end
                        end
                        count_d = count_q + 4'd1;
                        if (count_q == LAST_SLOT) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                IDLE, DONE: begin
                    if (bus.in_valid) begin
                        overrun_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.in_ready = (state_q == COLLECT);
    assign bus.out      = out_q;
    assign bus.done_out = done_q;
    assign bus.count    = count_q;
    assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_layer_result_packer.sv
// Directed and randomized frames for layer_result_packer, checked against a queue-based model
// of the accepted results.
module tb_layer_result_packer;
    localparam int N  = 10;
    localparam int DW = 16;
    localparam int SW = 2 * DW;
    localparam int OW = N * SW;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [SW-1:0] expQ[$];
    bit            expActive;
    bit            expOverrun;

    layer_result_packer_if #(.weightNo(N), .dataWidth(DW)) bus ();

    layer_result_packer #(.weightNo(N), .dataWidth(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: a frame is the list of results accepted since the last start
    function automatic logic [OW-1:0] packQ();
        logic [OW-1:0] v;
        v = '0;
        foreach (expQ[i]) v[i*SW +: SW] = expQ[i];
        return v;
    endfunction

    function automatic int argmaxOf(logic [OW-1:0] v);
        int best;
        best = 0;
        for (int k = 1; k < N; k++) begin
            if ($signed(v[k*SW +: SW]) > $signed(v[best*SW +: SW])) best = k;
        end
        return best;
    endfunction

    task automatic modelReset();
        expQ.delete();
        expActive  = 1'b0;
        expOverrun = 1'b0;
    endtask

    task automatic modelStep(bit s, bit v, logic [SW-1:0] d);
        if (s) begin
            expActive  = 1'b1;
            expOverrun = 1'b0;
            expQ.delete();
        end else if (v) begin
            if (expActive && expQ.size() < N) expQ.push_back(d);
            else expOverrun = 1'b1;
        end
    endtask

    task automatic checkVal(string tag, logic [OW-1:0] obs, logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(string tag);
        bit full;
        full = expActive && (expQ.size() == N);
        checkVal({tag, ".out"},      bus.out,                   packQ());
        checkVal({tag, ".count"},    OW'(bus.count),            OW'(expQ.size()));
        checkVal({tag, ".done_out"}, OW'(bus.done_out),         OW'(full));
        checkVal({tag, ".overrun"},  OW'(bus.overrun),          OW'(expOverrun));
        checkVal({tag, ".in_ready"}, OW'(bus.in_ready),         OW'(expActive && !full));
    endtask

    // drive one cycle of inputs, advance the model on the edge, then check away from the edge
    task automatic applyStimulus(string tag, bit s, bit v, logic [SW-1:0] d);
        bus.start    = s;
        bus.in_valid = v;
        bus.in_data  = d;
        @(posedge clk);
        modelStep(s, v, d);
        #1;
        checkOutput(tag);
    endtask

    task automatic randomFrame(string tag);
        int budget;
        applyStimulus({tag, ".start"}, 1'b1, 1'b0, '0);
        budget = 0;
        while (!(expActive && expQ.size() == N) && budget < 200) begin
            applyStimulus({tag, ".step"}, ($urandom_range(0, 40) == 0), ($urandom_range(0, 2) != 0), SW'($urandom));
            budget++;
        end
        checkVal({tag, ".budget"}, OW'(budget < 200), OW'(1));
        for (int i = 0; i < 3; i++) applyStimulus({tag, ".done"}, 1'b0, $urandom_range(0, 1) == 1, SW'($urandom));
    endtask

    initial begin
        logic [SW-1:0] frameB[N];
        logic [OW-1:0] heldOut;
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        modelReset();
        #3;
        checkOutput("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // back-to-back frame 0..9
        applyStimulus("f1.start", 1'b1, 1'b0, '0);
        for (int k = 0; k < N; k++) applyStimulus("f1.acc", 1'b0, 1'b1, SW'(k));
        for (int k = 0; k < N; k++) checkVal("f1.slot", OW'(bus.out[k*SW +: SW]), OW'(k));
        checkVal("f1.argmax", OW'(argmaxOf(bus.out)), OW'(9));
        applyStimulus("f1.hold", 1'b0, 1'b0, '0);

        // signed frame with a bubble between every accept
        frameB = '{-5, -3, -1, 7, 2, 0, -8, 3, 1, -2};
        applyStimulus("f2.start", 1'b1, 1'b0, '0);
        for (int k = 0; k < N; k++) begin
            applyStimulus("f2.acc",    1'b0, 1'b1, frameB[k]);
            applyStimulus("f2.bubble", 1'b0, 1'b0, SW'(32'hDEADBEEF));
        end
        checkVal("f2.slot6", OW'(bus.out[6*SW +: SW]), OW'(32'hFFFFFFF8));
        checkVal("f2.argmax", OW'(argmaxOf(bus.out)), OW'(3));

        // valid in DONE is dropped and flags overrun
        heldOut = packQ();
        applyStimulus("overrun.done", 1'b0, 1'b1, SW'(32'h12345678));
        checkVal("overrun.held", bus.out, heldOut);
        checkVal("overrun.flag", OW'(bus.overrun), OW'(1));

        // abort at count 4, then a complete frame
        applyStimulus("abort.start", 1'b1, 1'b0, '0);
        for (int k = 0; k < 4; k++) applyStimulus("abort.acc", 1'b0, 1'b1, SW'($urandom));
        applyStimulus("abort.restart", 1'b1, 1'b0, '0);
        for (int k = 0; k < N; k++) applyStimulus("abort.refill", 1'b0, 1'b1, SW'($urandom));

        // start together with valid at count 3
        applyStimulus("collide.start", 1'b1, 1'b0, '0);
        for (int k = 0; k < 3; k++) applyStimulus("collide.acc", 1'b0, 1'b1, SW'(100 + k));
        applyStimulus("collide.both", 1'b1, 1'b1, SW'(32'hCAFEF00D));
        applyStimulus("collide.next", 1'b0, 1'b1, SW'(32'h0000ABCD));

        // start and valid together in IDLE-like DONE state as well
        for (int k = 1; k < N; k++) applyStimulus("collide.fill", 1'b0, 1'b1, SW'($urandom));
        applyStimulus("done.both", 1'b1, 1'b1, SW'(32'h55555555));

        for (int f = 0; f < 4; f++) randomFrame("rand");

        // asynchronous reset mid-frame at count 6
        applyStimulus("areset.start", 1'b1, 1'b0, '0);
        for (int k = 0; k < 6; k++) applyStimulus("areset.acc", 1'b0, 1'b1, SW'($urandom));
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("areset.async");
        @(posedge clk);
        #1;
        checkOutput("areset.held");
        rst_n = 1'b1;
        applyStimulus("areset.stray", 1'b0, 1'b1, SW'(32'h0BADF00D));
        checkVal("areset.overrun", OW'(bus.overrun), OW'(1));
        applyStimulus("areset.idle", 1'b0, 1'b0, '0);
        applyStimulus("areset.start2", 1'b1, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
